// File: rtl/nvdla_csb_responder.sv
// CSB target stub for the NVDLA configuration bus. It answers reads and
// non-posted writes from a small local register bank and emulates one
// sub-unit operation. The operation runs for a fixed number of cycles and
// raises a level interrupt when it finishes; software clears the interrupt
// by writing 1 to the done bit.
//
// Handshake: a request is accepted on a rising edge where valid and ready are
// both 1. Ready is high whenever the bus FSM is idle. A read or a non-posted
// write moves the FSM to RESP. In RESP the response pulse is driven for
// exactly one cycle and no new request is taken. There is no response
// backpressure. A posted write leaves the FSM idle, so posted writes can be
// issued back to back on every cycle.
module nvdla_csb_responder #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h5000,
    parameter int                    N_REGS     = 16,
    parameter int                    OP_LATENCY = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csb_req_valid_i,
    output logic                  csb_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] csb_req_addr_i,
    input  logic [31:0]           csb_req_wdat_i,
    input  logic                  csb_req_write_i,
    input  logic                  csb_req_nposted_i,
    output logic                  csb_resp_valid_o,
    output logic [31:0]           csb_resp_rdata_o,
    output logic                  csb_resp_is_wack_o,
    output logic                  csb_resp_error_o,
    output logic                  intr_o,
    output logic                  busy_o
);

    localparam int IDX_W  = $clog2(N_REGS);
    localparam int N_SLOT = 2 ** IDX_W;
    localparam int CNT_W  = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;

    localparam logic [IDX_W-1:0] IDX_INTR_STATUS = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_OP_ENABLE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_FIRST_SCR   = IDX_W'(2);

    typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_e;
    typedef enum logic {OP_IDLE, OP_RUN}    op_state_e;

    bus_state_e       bus_state_q, bus_state_d;
    op_state_e        op_state_q, op_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [31:0]      regs_q [N_SLOT];
    logic [31:0]      resp_rdata_q;
    logic             resp_wack_q;
    logic             resp_err_q;

    logic                  accept;
    logic                  needs_resp;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH:0]   addr_ext, lo_ext, hi_ext;
    logic [31:0]           rd_data;
    logic                  start_op;
    logic                  w1c_done;
    logic                  done_set;
    logic                  resp_out;

    // Address decode and read-data mux. The compare is one bit wider than the
    // address, so a window that ends at the top of the address space does
    // not wrap around to zero.
    always_comb begin
        addr_ext = {1'b0, csb_req_addr_i};
        lo_ext   = {1'b0, BASE_ADDR};
        hi_ext   = lo_ext + (ADDR_WIDTH+1)'(N_REGS);
        hit      = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
        idx      = IDX_W'(csb_req_addr_i - BASE_ADDR);
        if (idx == IDX_INTR_STATUS) begin
            rd_data = {31'b0, done_q};
        end else if (idx == IDX_OP_ENABLE) begin
            rd_data = {31'b0, busy_o};
        end else begin
            rd_data = regs_q[idx];
        end
    end

    // Bus FSM next state and response outputs. The response is gated by
    // reset, so a pending response is dropped rather than pulsed.
    always_comb begin
        bus_state_d     = bus_state_q;
        csb_req_ready_o = (bus_state_q == BUS_IDLE);
        accept          = csb_req_valid_i && csb_req_ready_o;
        needs_resp      = !csb_req_write_i || csb_req_nposted_i;
        case (bus_state_q)
            BUS_IDLE: if (accept && needs_resp) bus_state_d = BUS_RESP;
            BUS_RESP: bus_state_d = BUS_IDLE;
            default:  bus_state_d = BUS_IDLE;
        endcase
        resp_out           = (bus_state_q == BUS_RESP) && !rst_i;
        csb_resp_valid_o   = resp_out;
        csb_resp_rdata_o   = resp_out ? resp_rdata_q : 32'h0;
        csb_resp_is_wack_o = resp_out && resp_wack_q;
        csb_resp_error_o   = resp_out && resp_err_q;
    end

    // Op FSM next state. A done edge wins over a W1C in the same cycle.
    always_comb begin
        op_state_d = op_state_q;
        cnt_d      = cnt_q;
        done_set   = 1'b0;
        start_op   = accept && csb_req_write_i && hit &&
                     (idx == IDX_OP_ENABLE) && csb_req_wdat_i[0];
        w1c_done   = accept && csb_req_write_i && hit &&
                     (idx == IDX_INTR_STATUS) && csb_req_wdat_i[0];
        case (op_state_q)
            OP_IDLE: begin
                if (start_op) begin
                    op_state_d = OP_RUN;
                    cnt_d      = CNT_W'(OP_LATENCY - 1);
                end
            end
            OP_RUN: begin
                if (cnt_q == '0) begin
                    op_state_d = OP_IDLE;
                    done_set   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: op_state_d = OP_IDLE;
        endcase
        done_d = done_set || (done_q && !w1c_done);
        busy_o = (op_state_q == OP_RUN);
        intr_o = done_q;
    end

    // Bus FSM state and response payload captured at the accept edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus_state_q  <= BUS_IDLE;
            resp_rdata_q <= 32'h0;
            resp_wack_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            bus_state_q <= bus_state_d;
            if (accept && needs_resp) begin
                resp_rdata_q <= (csb_req_write_i || !hit) ? 32'h0 : rd_data;
                resp_wack_q  <= csb_req_write_i;
                resp_err_q   <= !hit;
            end
        end
    end

    // Op FSM state, cycle counter and the done flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_state_q <= OP_IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            op_state_q <= op_state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    // Scratch register bank. Slots 0 and 1 are the control registers and
    // are never written here. Writes that miss the window are discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_SLOT; i++) regs_q[i] <= 32'h0;
        end else if (accept && csb_req_write_i && hit && (idx >= IDX_FIRST_SCR)) begin
            regs_q[idx] <= csb_req_wdat_i;
        end
    end

endmodule

// File: tb/tb_nvdla_csb_responder.sv
// Bench for nvdla_csb_responder. A transaction-level model follows every
// clock edge. The model holds the scratch array, the done flag, an "op
// running until edge N" record and an expected-response queue. A compare
// process checks the DUT outputs against the model 1 time unit after each
// rising edge. Directed tests pin the model with literal values, and a
// random phase follows them.
module tb_nvdla_csb_responder;

    localparam int BASE = 'h5000;
    localparam int NREG = 16;
    localparam int LAT  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdat = '0;
    logic        req_write = 1'b0;
    logic        req_nposted = 1'b0;
    logic        req_ready, resp_valid, resp_wack, resp_err, intr, busy;
    logic [31:0] resp_rdata;

    int checks = 0;
    int failures = 0;

    nvdla_csb_responder dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .csb_req_valid_i    (req_valid),
        .csb_req_ready_o    (req_ready),
        .csb_req_addr_i     (req_addr),
        .csb_req_wdat_i     (req_wdat),
        .csb_req_write_i    (req_write),
        .csb_req_nposted_i  (req_nposted),
        .csb_resp_valid_o   (resp_valid),
        .csb_resp_rdata_o   (resp_rdata),
        .csb_resp_is_wack_o (resp_wack),
        .csb_resp_error_o   (resp_err),
        .intr_o             (intr),
        .busy_o             (busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [33:0] exp_q[$];            // {is_wack, error, rdata}
    logic [31:0] m_scratch [NREG];
    bit          m_done = 1'b0;
    bit          m_running = 1'b0;
    longint      m_edge = 0;
    longint      m_done_edge = 0;
    bit          m_resp_now = 1'b0;
    bit          m_acc, m_hit, m_set_done, m_w1c, m_start;
    int          m_idx;
    logic [31:0] m_rd;

    always @(posedge clk) begin
        m_edge++;
        if (rst) begin
            m_resp_now = 1'b0;
            m_running  = 1'b0;
            m_done     = 1'b0;
            for (int i = 0; i < NREG; i++) m_scratch[i] = 32'h0;
            exp_q.delete();
        end else begin
            m_acc      = req_valid && !m_resp_now;
            m_resp_now = 1'b0;
            m_hit      = (int'(req_addr) >= BASE) && (int'(req_addr) < BASE + NREG);
            m_idx      = int'(req_addr) - BASE;
            m_set_done = m_running && (m_edge == m_done_edge);
            m_w1c      = m_acc && req_write && m_hit && m_idx == 0 && req_wdat[0];
            m_start    = m_acc && req_write && m_hit && m_idx == 1 && req_wdat[0] && !m_running;
            if (m_acc && !req_write) begin
                if (!m_hit)            m_rd = 32'h0;
                else if (m_idx == 0)   m_rd = {31'b0, m_done};
                else if (m_idx == 1)   m_rd = {31'b0, m_running};
                else                   m_rd = m_scratch[m_idx];
                exp_q.push_back({1'b0, !m_hit, m_rd});
                m_resp_now = 1'b1;
            end
            if (m_acc && req_write && req_nposted) begin
                exp_q.push_back({1'b1, !m_hit, 32'h0});
                m_resp_now = 1'b1;
            end
            if (m_acc && req_write && m_hit && m_idx >= 2) m_scratch[m_idx] = req_wdat;
            if (m_set_done) begin
                m_done    = 1'b1;
                m_running = 1'b0;
            end else if (m_w1c) begin
                m_done = 1'b0;
            end
            if (m_start) begin
                m_running   = 1'b1;
                m_done_edge = m_edge + LAT;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [33:0] sb_item;

    always @(posedge clk) begin
        #1;
        chk("ready", {31'b0, req_ready}, {31'b0, !m_resp_now});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_resp_now && !rst});
        chk("busy", {31'b0, busy}, {31'b0, m_running});
        chk("intr", {31'b0, intr}, {31'b0, m_done});
        if (resp_valid && m_resp_now && !rst) begin
            if (exp_q.size() == 0) begin
                chk("resp_queue_empty", 32'd1, 32'd0);
            end else begin
                sb_item = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, sb_item[31:0]);
                chk("resp_error", {31'b0, resp_err}, {31'b0, sb_item[32]});
                chk("resp_wack", {31'b0, resp_wack}, {31'b0, sb_item[33]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives a request at the falling edge and holds it until an edge where
    // ready was high. Returns just after the accepting rising edge, with
    // valid still asserted.
    task automatic send(input logic [15:0] addr, input logic [31:0] wdat,
                        input logic write, input logic nposted);
        bit accepted = 1'b0;
        @(negedge clk);
        req_valid   = 1'b1;
        req_addr    = addr;
        req_wdat    = wdat;
        req_write   = write;
        req_nposted = nposted;
        for (int n = 0; n < 8 && !accepted; n++) begin
            if (n > 0) @(negedge clk);
            accepted = req_ready;
            @(posedge clk);
        end
        if (!accepted) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int k);
        for (int n = 0; n < k; n++) begin
            @(negedge clk);
            req_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic reset_assert();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        send(addr, 32'h0, 1'b0, 1'b0);
        #1;
        chk({name, "_valid"}, {31'b0, resp_valid}, 32'd1);
        chk({name, "_rdata"}, resp_rdata, exp_data);
        chk({name, "_error"}, {31'b0, resp_err}, {31'b0, exp_err});
        chk({name, "_wack"}, {31'b0, resp_wack}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    int r;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_intr", {31'b0, intr}, 32'd0);
        reset_release();

        // 1: non-posted write then read back
        send(16'(BASE + 2), 32'hDEADBEEF, 1'b1, 1'b1);
        #1;
        chk("t1_wack_valid", {31'b0, resp_valid}, 32'd1);
        chk("t1_wack_flag", {31'b0, resp_wack}, 32'd1);
        chk("t1_wack_err", {31'b0, resp_err}, 32'd0);
        chk("t1_wack_rdata", resp_rdata, 32'd0);
        rd_check("t1_read", 16'(BASE + 2), 32'hDEADBEEF, 1'b0);

        // 2: back-to-back posted writes, then read back
        for (int i = 0; i < 4; i++) begin
            send(16'(BASE + 2 + i), 32'h1111_0000 + 32'(i), 1'b1, 1'b0);
            #1;
            chk("t2_ready", {31'b0, req_ready}, 32'd1);
            chk("t2_no_resp", {31'b0, resp_valid}, 32'd0);
        end
        for (int i = 0; i < 4; i++)
            rd_check("t2_read", 16'(BASE + 2 + i), 32'h1111_0000 + 32'(i), 1'b0);

        // 3: out-of-window reads and a discarded write
        rd_check("t3_above", 16'(BASE + NREG), 32'h0, 1'b1);
        rd_check("t3_below", 16'(BASE - 1), 32'h0, 1'b1);
        send(16'(BASE + NREG), 32'hFFFF_FFFF, 1'b1, 1'b0);
        rd_check("t3_scratch", 16'(BASE + 2), 32'h1111_0000, 1'b0);

        // 4: operation timing, ignored restart, W1C
        send(16'(BASE + 1), 32'h1, 1'b1, 1'b0);
        #1;
        chk("t4_busy_start", {31'b0, busy}, 32'd1);
        idle(4);
        send(16'(BASE + 1), 32'h1, 1'b1, 1'b0);
        idle(26);
        #1;
        chk("t4_busy_last", {31'b0, busy}, 32'd1);
        chk("t4_intr_before", {31'b0, intr}, 32'd0);
        idle(1);
        #1;
        chk("t4_busy_end", {31'b0, busy}, 32'd0);
        chk("t4_intr_set", {31'b0, intr}, 32'd1);
        send(16'(BASE + 0), 32'h1, 1'b1, 1'b0);
        #1;
        chk("t4_intr_clr", {31'b0, intr}, 32'd0);

        // 5: W1C on the done edge loses to set
        send(16'(BASE + 1), 32'h1, 1'b1, 1'b0);
        idle(31);
        send(16'(BASE + 0), 32'h1, 1'b1, 1'b0);
        #1;
        chk("t5_intr_held", {31'b0, intr}, 32'd1);
        chk("t5_busy_end", {31'b0, busy}, 32'd0);
        send(16'(BASE + 0), 32'h1, 1'b1, 1'b0);
        #1;
        chk("t5_intr_clr", {31'b0, intr}, 32'd0);

        // 6: reset mid-operation and mid-response
        send(16'(BASE + 1), 32'h1, 1'b1, 1'b0);
        idle(33);
        #1;
        chk("t6_done", {31'b0, intr}, 32'd1);
        send(16'(BASE + 1), 32'h1, 1'b1, 1'b0);
        #1;
        chk("t6_restart_busy", {31'b0, busy}, 32'd1);
        chk("t6_restart_intr", {31'b0, intr}, 32'd1);
        idle(9);
        reset_assert();
        #1;
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_intr", {31'b0, intr}, 32'd0);
        chk("t6_rst_ready", {31'b0, req_ready}, 32'd1);
        reset_release();
        send(16'(BASE + 3), 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("t6_resp_dropped", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_rst2_resp", {31'b0, resp_valid}, 32'd0);
        chk("t6_rst2_ready", {31'b0, req_ready}, 32'd1);
        reset_release();

        // random phase
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                send(16'(BASE + 1), $urandom, 1'b1, 1'($urandom_range(0, 1)));
            end else if (r < 14) begin
                send(16'(BASE + 0), $urandom, 1'b1, 1'($urandom_range(0, 1)));
            end else if (r < 17) begin
                reset_assert();
                reset_release();
            end else if (r < 25) begin
                idle($urandom_range(1, 40));
            end else begin
                send(16'(BASE - 2 + $urandom_range(0, NREG + 3)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        idle(40);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
